// File: rtl/stage5_dict_update.sv
// Serialises groups of up to three de-FAST messages onto a valid/ready stream,
// skipping default messages and capturing the header bytes of each emitted message.
// Optional skipped-message counter on err_cnt is enabled by defining STAGE5_ERR_CNT_EN.

`ifndef MAX_MESSAGE_BITS
`define MAX_MESSAGE_BITS 264
`endif
`ifndef field_PID1_bits
`define field_PID1_bits 8
`endif
`ifndef DEFAUT_MESSAGE
`define DEFAUT_MESSAGE 264'h0
`endif

module stage5_dict_update #(
    parameter int MSG_W   = `MAX_MESSAGE_BITS,
    parameter int FIELD_W = `field_PID1_bits,
    parameter int ERR_W   = 16,
    parameter logic [MSG_W-1:0] DEFAULT_MSG = `DEFAUT_MESSAGE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_mask,
    input  logic [MSG_W-1:0]   message_1,
    input  logic [MSG_W-1:0]   message_2,
    input  logic [MSG_W-1:0]   message_3,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [MSG_W-1:0]   out_message,
    output logic               out_last,
    output logic [FIELD_W-1:0] field_PID1,
    output logic [FIELD_W-1:0] field_MC1,
    output logic [FIELD_W-1:0] field_MT1
`ifdef STAGE5_ERR_CNT_EN
    ,
    output logic [ERR_W-1:0]   err_cnt
`endif
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t             state_reg, state_next;
    logic [1:0]         idx_reg, idx_next;
    logic [2:0]         mask_reg;
    logic [MSG_W-1:0]   buf_reg [3];
    logic [MSG_W-1:0]   msg_in [3];
    logic [2:0]         slot_default;
    logic [2:0]         higher_mask;
    logic               cur_default;
    logic               has_next;
    logic               accept;
    logic               advance;
    logic [FIELD_W-1:0] pid1_reg, mc1_reg, mt1_reg;

    function automatic logic [1:0] lowest_set(input logic [2:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else           return 2'd2;
    endfunction

    assign msg_in[0] = message_1;
    assign msg_in[1] = message_2;
    assign msg_in[2] = message_3;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_slot
            assign slot_default[gi] = (buf_reg[gi] == DEFAULT_MSG);

            always_ff @(posedge clk) begin
                if (!rst_n)
                    buf_reg[gi] <= '0;
                else if (accept)
                    buf_reg[gi] <= msg_in[gi];
            end
        end
    endgenerate

    // Slots above the current one that are still waiting in the buffer.
    always_comb begin
        higher_mask = 3'b000;
        case (idx_reg)
            2'd0:    higher_mask = mask_reg & 3'b110;
            2'd1:    higher_mask = mask_reg & 3'b100;
            default: higher_mask = 3'b000;
        endcase
    end

    assign cur_default = slot_default[idx_reg];
    assign has_next    = |higher_mask;
    assign accept      = (state_reg == IDLE) && in_valid;
    // A default slot leaves after one cycle regardless of out_ready.
    assign advance     = (state_reg == EMIT) && (cur_default || out_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= 2'd0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid && (in_mask != 3'b000)) begin
                    state_next = EMIT;
                    idx_next   = lowest_set(in_mask);
                end
            end
            EMIT: begin
                if (advance) begin
                    if (has_next)
                        idx_next = lowest_set(higher_mask);
                    else
                        state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready    = (state_reg == IDLE);
        out_valid   = (state_reg == EMIT) && !cur_default;
        out_message = out_valid ? buf_reg[idx_reg] : '0;
        out_last    = out_valid && !has_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            mask_reg <= 3'b000;
        else if (accept)
            mask_reg <= in_mask;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pid1_reg <= '0;
            mc1_reg  <= '0;
            mt1_reg  <= '0;
        end else if (out_valid && out_ready) begin
            pid1_reg <= out_message[MSG_W-1 -: FIELD_W];
            mc1_reg  <= out_message[MSG_W-1-FIELD_W -: FIELD_W];
            mt1_reg  <= out_message[MSG_W-1-2*FIELD_W -: FIELD_W];
        end
    end

    assign field_PID1 = pid1_reg;
    assign field_MC1  = mc1_reg;
    assign field_MT1  = mt1_reg;

`ifdef STAGE5_ERR_CNT_EN
    logic [ERR_W-1:0] err_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n)
            err_cnt_reg <= '0;
        else if ((state_reg == EMIT) && cur_default && (err_cnt_reg != {ERR_W{1'b1}}))
            err_cnt_reg <= err_cnt_reg + 1'b1;
    end

    assign err_cnt = err_cnt_reg;
`endif

endmodule

// File: doc/stage5_dict_update.md
Name: stage5_dict_update

Overview:
- Downstream neighbour of the stage-4 de-FAST block.
- Accepts a group of up to three reconstructed messages per transaction and serialises them onto a one-message-per-cycle valid/ready stream.
- For each emitted message, captures the PID1, MC1 and MT1 header bytes into the field dictionary registers. These registers feed back to stage 4 so copy-operator fields in later messages are restored from the last transmitted value.
- Skips default (error) messages without emitting them.

Parameters:
- MSG_W, 264, message width; equals `MAX_MESSAGE_BITS.
- FIELD_W, 8, width of each of field_PID1, field_MC1, field_MT1; equals `field_PID1_bits.
- ERR_W, 16, width of the skipped-message counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  message group present.
- in_ready  out  1  block can accept a group.
- in_mask  in  3  bit k set = message_(k+1) slot occupied.
- message_1  in  MSG_W  slot 0 message.
- message_2  in  MSG_W  slot 1 message.
- message_3  in  MSG_W  slot 2 message.
- out_valid  out  1  out_message valid.
- out_ready  in  1  downstream accepts.
- out_message  out  MSG_W  serialised message.
- out_last  out  1  final emitted message of the group.
- field_PID1  out  FIELD_W  dictionary value, taken from out_message[MSG_W-1 -: 8].
- field_MC1  out  FIELD_W  dictionary value, taken from out_message[MSG_W-9 -: 8].
- field_MT1  out  FIELD_W  dictionary value, taken from out_message[MSG_W-17 -: 8].
- err_cnt  out  ERR_W  skipped default-message count; present only with the optional feature.

Behaviour:
- Reset (rst_n=0 at a rising edge) forces:
  - state IDLE, in_ready=1, out_valid=0, out_last=0, out_message=0;
  - field_PID1=field_MC1=field_MT1=0, err_cnt=0, buffer mask=0.
  - Reset applied mid-group discards the buffered group; nothing further is emitted from it.
- States: IDLE, EMIT.
- in_ready = (state==IDLE). It is a registered-state decode, not dependent on out_ready.
- IDLE:
  - on in_valid&in_ready, latch the three messages and in_mask into the buffer.
  - mask==0: the group is dropped and the block stays in IDLE.
  - otherwise: go to EMIT with idx = lowest set mask bit.
- EMIT, slot idx:
  - The slot is "default" when buf[idx] == `defaut_message.
  - Default slot: out_valid=0 for one cycle; err_cnt increments (if enabled) and saturates at all-ones; the dictionary is unchanged; advance.
  - Non-default slot: out_valid=1, out_message=buf[idx], out_last=1 iff no higher mask bit is set.
  - out_valid, out_message and out_last are stable until out_ready.
  - On out_valid&out_ready, the dictionary loads the three header bytes of out_message; advance.
  - Advance means: idx = next higher set mask bit. If there is none, go to IDLE.
- Latency:
  - A group accepted at edge N presents its first non-default message from cycle N+1.
  - Group-to-group bubble is 1 cycle (the IDLE acceptance cycle).
- A dictionary update is visible on the field_* ports the cycle after the handshake edge. Ordering within a group is therefore sequential: slot 0 → 1 → 2.
- out_ready held low stalls indefinitely; no data is lost or changed while stalled.
- A group whose set slots are all default produces no out_valid and returns to IDLE. err_cnt increases by the number of such slots.
- in_mask bits set above the highest valid slot cannot occur, because only 3 bits exist. Unset slots are never emitted or counted.

Optional Feature:
- Macro: STAGE5_ERR_CNT_EN.
- Defined: err_cnt port and counter exist as described; saturating; cleared only by reset.
- Undefined: the err_cnt port and counter are removed. Default slots are still skipped in one cycle and still do not update the dictionary.

Test Plan:
- Reset, then idle → all outputs 0, in_ready=1. Assert rst_n=0 during EMIT of a 3-message group → next cycle out_valid=0, fields=0, in_ready=1.
- Group mask=3'b111, header bytes (0x11,0x22,0x33), (0x44,0x55,0x66), (0x77,0x88,0x99), out_ready=1:
  - three beats on consecutive cycles, out_last only on the third;
  - fields read 11/22/33, then 44/55/66, then 77/88/99, each one cycle after its beat.
- Mask=3'b101, out_ready low for 4 cycles:
  - slot 0 is held stable for the 4 cycles; slot 1 is never emitted; slot 2 carries out_last.
  - in_ready=0 throughout; in_ready=1 the cycle after the last handshake.
- Mask=3'b111 with slot 1 = `defaut_message:
  - slots 0 and 2 are emitted with one idle cycle between them; err_cnt=1.
  - Dictionary ends at slot 2's bytes, with slot 0's bytes before that.
- Mask=3'b000 with in_valid=1 → no out_valid, in_ready stays 1. All-default group mask=3'b011 → err_cnt +2, no beats.
- STAGE5_ERR_CNT_EN defined, err_cnt preloaded near max via 2^ERR_W default slots (reduced ERR_W=2 build) → count saturates at 3.
